// File: rtl/sdrio_rx_bitslip.sv
// sdrio_rx_bitslip: per-lane read-path word aligner behind the x1 DQ IO cell.
// It buffers two deserialized nibbles and trains a 0..3 bit rotation against a
// known pattern. After that it delivers realigned nibbles to the read datapath.
//
// Handshake: there is no back-pressure. rvalid is a one-cycle qualifier for
// rdata. It is high only when the lane is locked and the matching q_vld was
// high two cycles earlier. The controller pulses train_start for one cycle and
// then watches busy / locked / train_fail.
//
// dbg_state exposes the training FSM.
// Encoding: 0=IDLE 1=SETTLE 2=CHECK 3=LOCKED 4=FAIL.
module sdrio_rx_bitslip #(
    parameter logic [3:0]  TRAIN_PAT  = 4'b0001,
    parameter int unsigned SETTLE_CYC = 4,
    parameter int unsigned MATCH_CNT  = 8
) (
    input  logic       gsclk_il,
    input  logic       rst,
    input  logic [3:0] q_in,
    input  logic       q_vld,
    input  logic       train_start,
    output logic [3:0] rdata,
    output logic       rvalid,
    output logic [1:0] slip,
    output logic       locked,
    output logic       train_fail,
    output logic       busy,
    output logic [2:0] dbg_state
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETTLE = 3'd1;
    localparam logic [2:0] ST_CHECK  = 3'd2;
    localparam logic [2:0] ST_LOCKED = 3'd3;
    localparam logic [2:0] ST_FAIL   = 3'd4;

    // Terminal counts. The 4-bit counter holds both, so it never wraps.
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);
    localparam logic [3:0] MATCH_LAST  = 4'(MATCH_CNT - 1);

    // Datapath registers
    logic [3:0] cur_q;
    logic [3:0] prev_q;
    logic [3:0] rdata_q;
    logic       v1_q;
    logic       v2_q;
    logic       rvalid_q;

    // Control registers
    logic [2:0] state_q, state_d;
    logic [1:0] slip_q, slip_d;
    logic [3:0] cnt_q, cnt_d;
    logic       locked_q, locked_d;
    logic       fail_q, fail_d;
    logic       busy_q, busy_d;

    // The newer nibble sits in the upper half because bit 0 is the earliest bit.
    logic [7:0] window;
    logic [7:0] window_sh;
    logic [3:0] aligned;
    logic       pat_match;

    // Select the 4-bit slice of the two-nibble window that starts at the current slip.
    always_comb begin
        window    = {cur_q, prev_q};
        window_sh = window >> slip_q;
        aligned   = window_sh[3:0];
        pat_match = (aligned == TRAIN_PAT);
    end

    // Nibble and valid pipelines. rdata follows the aligner even before lock.
    always_ff @(posedge gsclk_il) begin
        if (rst) begin
            cur_q    <= 4'd0;
            prev_q   <= 4'd0;
            rdata_q  <= 4'd0;
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            rvalid_q <= 1'b0;
        end else begin
            cur_q    <= q_in;
            prev_q   <= cur_q;
            rdata_q  <= aligned;
            v1_q     <= q_vld;
            v2_q     <= v1_q;
            rvalid_q <= v2_q & locked_q;
        end
    end

    // Training FSM next state. train_start overrides every state, including mid-training.
    always_comb begin
        state_d = state_q;
        slip_d  = slip_q;
        cnt_d   = cnt_q;
        if (train_start) begin
            state_d = ST_SETTLE;
            slip_d  = 2'd0;
            cnt_d   = 4'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_SETTLE: begin
                    // Let the new slip flush through the window before trusting it.
                    if (cnt_q == SETTLE_LAST) begin
                        cnt_d   = 4'd0;
                        state_d = ST_CHECK;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                ST_CHECK: begin
                    if (pat_match) begin
                        if (cnt_q == MATCH_LAST) begin
                            state_d = ST_LOCKED;
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end else if (slip_q != 2'd3) begin
                        slip_d  = slip_q + 2'd1;
                        cnt_d   = 4'd0;
                        state_d = ST_SETTLE;
                    end else begin
                        state_d = ST_FAIL;
                    end
                end
                ST_LOCKED: begin
                    state_d = ST_LOCKED;
                end
                ST_FAIL: begin
                    state_d = ST_FAIL;
                end
                default: begin
                    state_d = ST_IDLE;
                    slip_d  = 2'd0;
                    cnt_d   = 4'd0;
                end
            endcase
        end
    end

    // Decode the status flags from the next state so that they switch on the same edge as the FSM.
    always_comb begin
        locked_d = (state_d == ST_LOCKED);
        fail_d   = (state_d == ST_FAIL);
        busy_d   = (state_d == ST_SETTLE) || (state_d == ST_CHECK);
    end

    // Control state registers. rst wins over a coincident train_start.
    always_ff @(posedge gsclk_il) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            slip_q   <= 2'd0;
            cnt_q    <= 4'd0;
            locked_q <= 1'b0;
            fail_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            slip_q   <= slip_d;
            cnt_q    <= cnt_d;
            locked_q <= locked_d;
            fail_q   <= fail_d;
            busy_q   <= busy_d;
        end
    end

    // Output mapping
    always_comb begin
        rdata      = rdata_q;
        rvalid     = rvalid_q;
        slip       = slip_q;
        locked     = locked_q;
        train_fail = fail_q;
        busy       = busy_q;
        dbg_state  = state_q;
    end

endmodule

// File: tb/tb_sdrio_rx_bitslip.sv
// tb_sdrio_rx_bitslip: directed bench for the bitslip aligner.
// Expected rdata words are queued when q_vld is driven on a locked lane.
// They are popped each time rvalid is seen.
module tb_sdrio_rx_bitslip;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CHECK  = 3'd2;
    localparam logic [2:0] ST_LOCKED = 3'd3;
    localparam logic [2:0] ST_FAIL   = 3'd4;
    localparam int LOCK_EDGES = 1 + 4 + 8;

    // Clock / reset
    logic       clk;
    logic       rst;
    logic [3:0] q_in;
    logic       q_vld;
    logic       train_start;
    logic [3:0] rdata;
    logic       rvalid;
    logic [1:0] slip;
    logic       locked;
    logic       train_fail;
    logic       busy;
    logic [2:0] dbg_state;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    sdrio_rx_bitslip dut (
        .gsclk_il    (clk),
        .rst         (rst),
        .q_in        (q_in),
        .q_vld       (q_vld),
        .train_start (train_start),
        .rdata       (rdata),
        .rvalid      (rvalid),
        .slip        (slip),
        .locked      (locked),
        .train_fail  (train_fail),
        .busy        (busy),
        .dbg_state   (dbg_state)
    );

    // Scoreboard
    logic [3:0] exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         rv_seen = 0;
    logic       sb_on = 1'b0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample at the falling edge. The scoreboard is consumed on rvalid.
    task automatic cyc();
        logic [3:0] e;
        @(posedge clk);
        @(negedge clk);
        if (sb_on && rvalid === 1'b1) begin
            rv_seen++;
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_rvalid", {7'd0, rvalid}, 8'd0);
            end else begin
                e = exp_q.pop_front();
                chk("sb_rdata", {4'd0, rdata}, {4'd0, e});
            end
        end
    endtask

    // Pulse train_start, then check busy throughout and lock on exactly the LOCK_EDGES-th edge.
    task automatic timed_lock(input string tag);
        train_start = 1'b1;
        cyc();
        train_start = 1'b0;
        for (int n = 2; n <= LOCK_EDGES; n++) begin
            chk({tag, "_busy"}, {7'd0, busy}, 8'd1);
            chk({tag, "_nolock"}, {7'd0, locked}, 8'd0);
            cyc();
        end
        chk({tag, "_locked"}, {7'd0, locked}, 8'd1);
        chk({tag, "_busy_off"}, {7'd0, busy}, 8'd0);
        chk({tag, "_nofail"}, {7'd0, train_fail}, 8'd0);
        chk({tag, "_slip"}, {6'd0, slip}, 8'd0);
    endtask

    // Train on a constant nibble and wait (bounded) for lock or fail.
    task automatic train_const(input logic [3:0] val);
        int i;
        q_in = val;
        train_start = 1'b1;
        cyc();
        train_start = 1'b0;
        for (i = 0; i < 200; i++) begin
            if (locked || train_fail) break;
            cyc();
        end
        chk("train_done_in_time", {7'd0, (locked | train_fail)}, 8'd1);
    endtask

    initial begin
        rst = 1'b1;
        q_in = 4'd0;
        q_vld = 1'b1;
        train_start = 1'b0;

        // Reset with random data and an open read window
        for (int i = 0; i < 3; i++) begin
            q_in = 4'($urandom_range(0, 15));
            cyc();
        end
        chk("rst_rdata", {4'd0, rdata}, 8'd0);
        chk("rst_rvalid", {7'd0, rvalid}, 8'd0);
        chk("rst_slip", {6'd0, slip}, 8'd0);
        chk("rst_locked", {7'd0, locked}, 8'd0);
        chk("rst_fail", {7'd0, train_fail}, 8'd0);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        chk("rst_state", {5'd0, dbg_state}, {5'd0, ST_IDLE});
        rst = 1'b0;
        q_vld = 1'b0;
        q_in = 4'b0001;
        cyc();
        cyc();

        // Already-aligned pattern: lock at slip 0 with exact timing
        timed_lock("lock0");

        // Slip 2, followed by a realigned read beat
        train_const(4'b0100);
        chk("s2_slip", {6'd0, slip}, 8'd2);
        chk("s2_locked", {7'd0, locked}, 8'd1);
        sb_on = 1'b1;
        rv_seen = 0;
        q_vld = 1'b1;
        exp_q.push_back(4'b0001);
        cyc();
        chk("s2_rvalid_e0", {7'd0, rvalid}, 8'd0);
        q_vld = 1'b0;
        cyc();
        chk("s2_rvalid_e1", {7'd0, rvalid}, 8'd0);
        cyc();
        chk("s2_rvalid_e2", {7'd0, rvalid}, 8'd1);
        chk("s2_rdata_e2", {4'd0, rdata}, 8'h01);
        cyc();
        chk("s2_rvalid_e3", {7'd0, rvalid}, 8'd0);
        chk("s2_beats", rv_seen[7:0], 8'd1);

        // Slip 1 and slip 3
        train_const(4'b0010);
        chk("s1_slip", {6'd0, slip}, 8'd1);
        chk("s1_locked", {7'd0, locked}, 8'd1);
        train_const(4'b1000);
        chk("s3_slip", {6'd0, slip}, 8'd3);
        chk("s3_locked", {7'd0, locked}, 8'd1);
        chk("s3_state", {5'd0, dbg_state}, {5'd0, ST_LOCKED});

        // Alternating data: no rotation holds, so training fails
        q_in = 4'b0001;
        train_start = 1'b1;
        cyc();
        train_start = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (train_fail || locked) break;
            q_in = i[0] ? 4'b0001 : 4'b1111;
            cyc();
        end
        chk("alt_fail", {7'd0, train_fail}, 8'd1);
        chk("alt_locked", {7'd0, locked}, 8'd0);
        chk("alt_slip", {6'd0, slip}, 8'd3);
        chk("alt_busy", {7'd0, busy}, 8'd0);
        chk("alt_state", {5'd0, dbg_state}, {5'd0, ST_FAIL});

        // Restart from mid-CHECK at slip 1
        q_in = 4'b0010;
        train_start = 1'b1;
        cyc();
        train_start = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (dbg_state == ST_CHECK && slip == 2'd1) break;
            cyc();
        end
        chk("rs_in_check", {5'd0, dbg_state}, {5'd0, ST_CHECK});
        chk("rs_at_slip1", {6'd0, slip}, 8'd1);
        cyc();
        q_in = 4'b0001;
        timed_lock("restart");

        // Locked passthrough at slip 0
        rv_seen = 0;
        q_vld = 1'b1;
        q_in = 4'hA; exp_q.push_back(4'hA); cyc();
        q_in = 4'h5; exp_q.push_back(4'h5); cyc();
        q_in = 4'hC; exp_q.push_back(4'hC); cyc();
        q_in = 4'h3; exp_q.push_back(4'h3); cyc();
        q_vld = 1'b0;
        q_in = 4'b0001;
        for (int i = 0; i < 6; i++) cyc();
        chk("pt_beats", rv_seen[7:0], 8'd4);
        chk("pt_queue_empty", 8'(exp_q.size()), 8'd0);

        // Reset while locked and streaming
        sb_on = 1'b0;
        q_vld = 1'b1;
        for (int i = 0; i < 3; i++) cyc();
        chk("rl_rvalid_pre", {7'd0, rvalid}, 8'd1);
        rst = 1'b1;
        cyc();
        chk("rl_rvalid", {7'd0, rvalid}, 8'd0);
        chk("rl_locked", {7'd0, locked}, 8'd0);
        chk("rl_state", {5'd0, dbg_state}, {5'd0, ST_IDLE});
        chk("rl_rdata", {4'd0, rdata}, 8'd0);
        rst = 1'b0;
        q_vld = 1'b0;
        cyc();

        // rst and train_start together: reset wins
        rst = 1'b1;
        train_start = 1'b1;
        cyc();
        rst = 1'b0;
        train_start = 1'b0;
        chk("rt_busy", {7'd0, busy}, 8'd0);
        chk("rt_state", {5'd0, dbg_state}, {5'd0, ST_IDLE});
        cyc();
        chk("rt_still_idle", {5'd0, dbg_state}, {5'd0, ST_IDLE});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
